aes_sha3_host_link: RTL and testbench
=====================================

# aes_sha3_host_link

Host-side link controller for the byte-serial AES + HMAC-SHA3 crypto core. It does both directions of the core's byte protocol. It serializes a 32-byte salt‖key word and 16-byte message blocks onto the core's `i_start`/`i_data` input. It deserializes the core's `o_valid`/`o_data` stream into a 128-bit ciphertext and a 256-bit HMAC tag. It sits between a word-oriented system bus and the core, with one outstanding operation at a time.

## Interface
- `TIMEOUT_CYCLES`, 4096, watchdog limit in cycles (used only with `AES_LINK_TIMEOUT_EN`).
- `clk`  in  1  single clock for the link and the core.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cfg_valid` / `cfg_ready`  in/out  1/1  salt‖key handshake.
- `cfg_data`  in  256  salt in [255:128], key in [127:0].
- `msg_valid` / `msg_ready`  in/out  1/1  message handshake.
- `msg_data`  in  128  plaintext or ciphertext block.
- `msg_mode`  in  1  encrypt/decrypt select; latched with the message.
- `res_valid` / `res_ready`  out/in  1/1  result handshake.
- `res_cipher`  out  128  AES output block.
- `res_tag`  out  256  HMAC tag.
- `err`  out  1  sticky protocol or timeout error.
- `core_start`  out  1  drives core `i_start`.
- `core_data`  out  8  drives core `i_data`.
- `core_mode`  out  1  drives core `i_mode`.
- `core_ien`  in  1  core `o_ien`; high means the core is busy.
- `core_valid`  in  1  core `o_valid`.
- `core_rdata`  in  8  core `o_data`.

## Operation
- **States:** NOKEY, KEY_TX, KEY_BUSY, KEY_DONE, READY, MSG_TX, RX_CIPHER, RX_GAP, RX_TAG, RES_HOLD, ERR.
- **NOKEY:** `cfg_ready` = 1. When `cfg_valid` is high, capture `cfg_data` and go to KEY_TX.
- **KEY_TX:** 32 cycles. `core_start` = 1 and `core_data` = next byte, MSB-first (`cfg_data[255:248]` first). After byte 31, go to KEY_BUSY.
- **KEY_BUSY:** wait for `core_ien` = 1, then go to KEY_DONE.
- **KEY_DONE:** wait for `core_ien` = 0, then go to READY. This covers key derivation, roughly 16 × 2 × 2 × 25 cycles.
- **READY:** `msg_ready` = 1. When `msg_valid` is high, capture `msg_data` and `msg_mode`, and go to MSG_TX.
- **MSG_TX:** 16 cycles, `core_data` MSB-first (`msg_data[127:120]` first). `core_start` = 1 on byte 0 only. Then go to RX_CIPHER.
- **RX_CIPHER:** count 16 bytes on `core_valid`. Byte k goes to `res_cipher[8k+7:8k]`, least-significant byte first. Then go to RX_GAP.
- **RX_GAP:** exactly one cycle with `core_valid` = 0. If `core_valid` = 1 here, go to ERR.
- **RX_TAG:** count 32 bytes. Byte k goes to `res_tag[8k+7:8k]`. Then go to RES_HOLD.
- **RES_HOLD:** `res_valid` = 1. Outputs stay stable until `res_ready`. On `res_ready`, go to READY once `core_ien` = 0.
- **`core_mode`:** holds the latched mode from MSG_TX through RES_HOLD.
- **Rekey:** requires `rst_n`. `cfg_valid` outside NOKEY is ignored.
- **`core_valid` = 1 in NOKEY, KEY_*, READY or MSG_TX:** go to ERR. ERR sets `err` = 1 and is left only by reset.
- **Idle outputs:** when not transmitting, `core_start` = 0 and `core_data` = 0.

## Timing
- **Reset values:** every output is 0; state is NOKEY; all buffers are 0.
- **Reset mid-operation:** `rst_n` low on any edge aborts the operation and clears results. `rst_n` is shared with the core, so both restart together.
- **Outputs:** all are registered. `cfg_ready` and `msg_ready` are Moore outputs with no combinational path from valid to ready.
- **Key load:** `cfg_valid` and `cfg_ready` high together at edge N gives the first key byte on the core input at cycle N+1, and the 32nd at N+32.
- **Message latency:** 16 transmit cycles, then the core's AES time, then 16 + 1 + 32 = 49 receive cycles. `res_valid` rises the cycle after the final tag byte.
- **Back-to-back messages:** `msg_ready` re-asserts at the earliest one cycle after the RES_HOLD handshake.

## Configuration
- **`AES_LINK_TIMEOUT_EN` defined:**
  - A 16-bit watchdog counts cycles in KEY_BUSY, KEY_DONE, RX_CIPHER, RX_GAP and RX_TAG.
  - It resets on every state change and every received byte.
  - When it reaches `TIMEOUT_CYCLES`, the link goes to ERR.
- **Undefined:** no watchdog logic is built. The link waits indefinitely, and `TIMEOUT_CYCLES` is unused.

## Structure
- **Package `aes_link_pkg`:**
  - state enum;
  - `KEY_BYTES` = 32, `MSG_BYTES` = 16, `CIPHER_BYTES` = 16, `TAG_BYTES` = 32.
- **Sub-module `byte_serializer`:** loadable 256-bit MSB-first shift register with a byte counter and a done pulse. Used for both the key and the message transmit.

## Test plan
- **Key load:** `cfg_data` = 0x00…1F (bytes 0–31), core model → `core_data` sequence 0x00, 0x01 … 0x1F with `core_start` high for 32 cycles. `msg_ready` rises after `core_ien` goes 1 then 0.
- **Single block:** `msg_data` = 0x00112233…EEFF, `msg_mode` = 1.
  - `core_data` = 0x00, 0x11, … over 16 cycles, `core_start` on byte 0 only, `core_mode` = 1.
  - Model returns cipher bytes 0x10…0x1F, gap, tag bytes 0x20…0x3F.
  - Required: `res_cipher` = 0x1F1E…1110, `res_tag` = 0x3F3E…2120.
- **Backpressure:** hold `res_ready` = 0 for 50 cycles → `res_valid` and data stable, `msg_ready` = 0. Release → one handshake, then READY.
- **Protocol error:** `core_valid` = 1 in RX_GAP → `err` = 1 next cycle and stays 1 until reset.
- **Timeout** (with `AES_LINK_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 64): model never drops `core_ien` → `err` = 1 at cycle 64 of KEY_DONE. Without the macro, no error after 10000 cycles.
- **Mid-message reset:** `rst_n` = 0 during RX_TAG byte 10 → next cycle all outputs 0, state NOKEY, `cfg_ready` = 1.

Source files
------------

// File: rtl/aes_link_pkg.sv
// Shared types and constants for the AES + HMAC-SHA3 host link.
package aes_link_pkg;

  typedef enum logic [3:0] {
    ST_NOKEY,
    ST_KEY_TX,
    ST_KEY_BUSY,
    ST_KEY_DONE,
    ST_READY,
    ST_MSG_TX,
    ST_RX_CIPHER,
    ST_RX_GAP,
    ST_RX_TAG,
    ST_RES_HOLD,
    ST_ERR
  } link_state_t;

  localparam int KEY_BYTES    = 32;
  localparam int MSG_BYTES    = 16;
  localparam int CIPHER_BYTES = 16;
  localparam int TAG_BYTES    = 32;

  // Wide enough to hold the longest transmit length (the salt/key word).
  localparam int SER_CNT_W = $clog2(KEY_BYTES + 1);

  // States in which the core has no business presenting output bytes.
  function automatic logic valid_forbidden(input link_state_t s);
    return (s == ST_NOKEY) || (s == ST_KEY_TX) || (s == ST_KEY_BUSY) ||
           (s == ST_KEY_DONE) || (s == ST_READY) || (s == ST_MSG_TX);
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Loadable 256-bit MSB-first shift register feeding the core byte input.
// done is high while the final byte of a load is on the output.
module byte_serializer
  import aes_link_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic [255:0]         load_data,
  input  logic [SER_CNT_W-1:0] load_len,
  input  logic                 start_all,
  output logic [7:0]           byte_out,
  output logic                 start_out,
  output logic                 done
);

  logic [255:0]         shreg;
  logic [SER_CNT_W-1:0] remain;
  logic                 busy;
  logic                 start_all_q;

  assign done = busy && (remain == '0);

  // Present one byte per cycle; start strobe on every byte or only the first.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg       <= '0;
      remain      <= '0;
      busy        <= 1'b0;
      start_all_q <= 1'b0;
      byte_out    <= 8'd0;
      start_out   <= 1'b0;
    end else if (load) begin
      byte_out    <= load_data[255:248];
      shreg       <= {load_data[247:0], 8'd0};
      remain      <= load_len - SER_CNT_W'(1);
      busy        <= 1'b1;
      start_all_q <= start_all;
      start_out   <= 1'b1;
    end else if (busy) begin
      if (remain == '0) begin
        busy        <= 1'b0;
        start_all_q <= 1'b0;
        byte_out    <= 8'd0;
        start_out   <= 1'b0;
      end else begin
        byte_out  <= shreg[255:248];
        shreg     <= {shreg[247:0], 8'd0};
        remain    <= remain - SER_CNT_W'(1);
        start_out <= start_all_q;
      end
    end
  end

endmodule

// File: rtl/aes_sha3_host_link.sv
// Host link for the byte-serial AES + HMAC-SHA3 core: sends salt/key and
// message blocks, collects ciphertext and tag. Optional watchdog is built
// when AES_LINK_TIMEOUT_EN is defined.
module aes_sha3_host_link
  import aes_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [255:0] cfg_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [127:0] msg_data,
  input  logic         msg_mode,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_cipher,
  output logic [255:0] res_tag,
  output logic         err,
  output logic         core_start,
  output logic [7:0]   core_data,
  output logic         core_mode,
  input  logic         core_ien,
  input  logic         core_valid,
  input  logic [7:0]   core_rdata
);

  link_state_t          state;
  logic [4:0]           rx_cnt;
  logic                 key_go;
  logic                 msg_go;
  logic                 err_hit;
  logic                 ser_load;
  logic                 ser_done;
  logic [255:0]         ser_data;
  logic [SER_CNT_W-1:0] ser_len;
  logic                 timeout;

  assign err_hit  = core_valid && valid_forbidden(state);
  assign key_go   = (state == ST_NOKEY) && cfg_valid && cfg_ready && !core_valid;
  assign msg_go   = (state == ST_READY) && msg_valid && msg_ready && !core_valid;
  assign ser_load = key_go || msg_go;
  assign ser_data = key_go ? cfg_data : {msg_data, 128'd0};
  assign ser_len  = key_go ? SER_CNT_W'(KEY_BYTES) : SER_CNT_W'(MSG_BYTES);

  byte_serializer u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (err_hit),
    .load      (ser_load),
    .load_data (ser_data),
    .load_len  (ser_len),
    .start_all (key_go),
    .byte_out  (core_data),
    .start_out (core_start),
    .done      (ser_done)
  );

`ifdef AES_LINK_TIMEOUT_EN
  logic [15:0] wd_cnt;
  link_state_t wd_state;
  logic        wd_watch;
  logic        byte_rx;

  assign wd_watch = state inside {ST_KEY_BUSY, ST_KEY_DONE, ST_RX_CIPHER, ST_RX_GAP, ST_RX_TAG};
  assign byte_rx  = core_valid && ((state == ST_RX_CIPHER) || (state == ST_RX_TAG));
  assign timeout  = wd_watch && (state == wd_state) && !byte_rx &&
                    (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog restarts on any state change or received byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt   <= 16'd0;
      wd_state <= ST_NOKEY;
    end else begin
      wd_state <= state;
      if (!wd_watch || (state != wd_state) || byte_rx) begin
        wd_cnt <= 16'd0;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end
`else
  // Without the watchdog the link waits forever; the limit has no effect.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Link sequencer with registered handshake, result and error outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_NOKEY;
      rx_cnt     <= 5'd0;
      cfg_ready  <= 1'b0;
      msg_ready  <= 1'b0;
      res_valid  <= 1'b0;
      res_cipher <= '0;
      res_tag    <= '0;
      err        <= 1'b0;
      core_mode  <= 1'b0;
    end else begin
      cfg_ready <= 1'b0;
      msg_ready <= 1'b0;
      if (err_hit || timeout) begin
        state     <= ST_ERR;
        err       <= 1'b1;
        res_valid <= 1'b0;
        core_mode <= 1'b0;
      end else begin
        case (state)
          ST_NOKEY: begin
            if (key_go) state <= ST_KEY_TX;
            else        cfg_ready <= 1'b1;
          end
          ST_KEY_TX: begin
            if (ser_done) state <= ST_KEY_BUSY;
          end
          ST_KEY_BUSY: begin
            if (core_ien) state <= ST_KEY_DONE;
          end
          ST_KEY_DONE: begin
            if (!core_ien) begin
              state     <= ST_READY;
              msg_ready <= 1'b1;
            end
          end
          ST_READY: begin
            if (msg_go) begin
              state     <= ST_MSG_TX;
              core_mode <= msg_mode;
            end else begin
              msg_ready <= 1'b1;
            end
          end
          ST_MSG_TX: begin
            if (ser_done) begin
              state  <= ST_RX_CIPHER;
              rx_cnt <= 5'd0;
            end
          end
          ST_RX_CIPHER: begin
            if (core_valid) begin
              res_cipher[{rx_cnt[3:0], 3'b000} +: 8] <= core_rdata;
              if (rx_cnt == 5'(CIPHER_BYTES - 1)) begin
                state  <= ST_RX_GAP;
                rx_cnt <= 5'd0;
              end else begin
                rx_cnt <= rx_cnt + 5'd1;
              end
            end
          end
          ST_RX_GAP: begin
            if (core_valid) begin
              state     <= ST_ERR;
              err       <= 1'b1;
              core_mode <= 1'b0;
            end else begin
              state <= ST_RX_TAG;
            end
          end
          ST_RX_TAG: begin
            if (core_valid) begin
              res_tag[{rx_cnt, 3'b000} +: 8] <= core_rdata;
              if (rx_cnt == 5'(TAG_BYTES - 1)) begin
                state     <= ST_RES_HOLD;
                res_valid <= 1'b1;
                rx_cnt    <= 5'd0;
              end else begin
                rx_cnt <= rx_cnt + 5'd1;
              end
            end
          end
          ST_RES_HOLD: begin
            if (!res_valid || res_ready) begin
              res_valid <= 1'b0;
              if (!core_ien) begin
                state     <= ST_READY;
                msg_ready <= 1'b1;
                core_mode <= 1'b0;
              end
            end
          end
          ST_ERR: begin
            err <= 1'b1;
          end
          default: begin
            state <= ST_ERR;
            err   <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_sha3_host_link.sv
// Self-checking bench for aes_sha3_host_link with a behavioural core model.
`timescale 1ns/1ps
module tb_aes_sha3_host_link;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [255:0] cfg_data;
  logic         msg_valid;
  logic         msg_ready;
  logic [127:0] msg_data;
  logic         msg_mode;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_cipher;
  logic [255:0] res_tag;
  logic         err;
  logic         core_start;
  logic [7:0]   core_data;
  logic         core_mode;
  logic         core_ien;
  logic         core_valid;
  logic [7:0]   core_rdata;

  logic [397:0] all_outs;
  assign all_outs = {cfg_ready, msg_ready, res_valid, res_cipher, res_tag,
                     err, core_start, core_data, core_mode};

  logic [7:0] cbytes[16];
  logic [7:0] tbytes[32];

  int checks_total  = 0;
  int checks_passed = 0;

  aes_sha3_host_link #(.TIMEOUT_CYCLES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .msg_mode   (msg_mode),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_cipher (res_cipher),
    .res_tag    (res_tag),
    .err        (err),
    .core_start (core_start),
    .core_data  (core_data),
    .core_mode  (core_mode),
    .core_ien   (core_ien),
    .core_valid (core_valid),
    .core_rdata (core_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; msg_valid = 1'b0; res_ready = 1'b0;
    core_ien = 1'b0; core_valid = 1'b0; core_rdata = 8'd0;
    cfg_data = '0; msg_data = '0; msg_mode = 1'b0;
    tick();
    tick();
    checkOutput("reset_outputs", 512'(all_outs), 512'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("reset_cfg_ready", 512'({msg_ready, cfg_ready}), 512'(2'b01));
  endtask

  // Hand the key over and record what appears on the core input.
  task automatic send_key(input logic [255:0] key);
    logic [255:0] seen;
    int starts;
    cfg_data = key; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_data = {8{$urandom()}};
    seen = '0; starts = 0;
    for (int k = 0; k < 32; k++) begin
      seen = {seen[247:0], core_data};
      starts += int'(core_start);
      tick();
    end
    checkOutput("key_bytes", 512'(seen), 512'(key));
    checkOutput("key_start_count", 512'(starts), 512'(32));
    checkOutput("key_idle", 512'({core_start, core_data}), 512'd0);
  endtask

  // Core model for key derivation: busy for a while, then idle again.
  task automatic finish_key(input int hold);
    bit bad;
    bad = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      tick();
      if (msg_ready !== 1'b0) bad = 1'b1;
    end
    core_ien = 1'b1;
    repeat (hold) begin
      tick();
      if (msg_ready !== 1'b0) bad = 1'b1;
    end
    checkOutput("key_busy_no_ready", 512'(bad), 512'd0);
    core_ien = 1'b0;
    tick();
    checkOutput("key_ready", 512'({msg_ready, cfg_ready, err}), 512'(3'b100));
  endtask

  // One message through the link; inject 1 = data in the gap, 2 = reset at tag byte 10.
  task automatic applyStimulus(input logic [127:0] msg, input logic mode,
                               input int aes_delay, input int tail, input int hold,
                               input int inject);
    logic [127:0] seen;
    logic [127:0] exp_cipher;
    logic [255:0] exp_tag;
    int  starts;
    int  tail_left;
    bit  start_first;
    bit  mode_bad;
    bit  hold_bad;
    exp_cipher = '0;
    exp_tag = '0;
    for (int k = 0; k < 16; k++) exp_cipher |= 128'(cbytes[k]) << (8 * k);
    for (int k = 0; k < 32; k++) exp_tag |= 256'(tbytes[k]) << (8 * k);
    tail_left = tail;
    msg_data = msg; msg_mode = mode; msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    msg_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    msg_mode = ~mode;
    seen = '0; starts = 0; start_first = 1'b0; mode_bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      seen = {seen[119:0], core_data};
      starts += int'(core_start);
      if (k == 0) start_first = core_start;
      if (core_mode !== mode) mode_bad = 1'b1;
      tick();
    end
    checkOutput("msg_bytes", 512'(seen), 512'(msg));
    checkOutput("msg_start", 512'({start_first, starts[7:0]}), 512'({1'b1, 8'd1}));
    checkOutput("msg_idle", 512'({core_start, core_data}), 512'd0);
    core_ien = 1'b1;
    repeat (aes_delay) begin
      if (core_mode !== mode) mode_bad = 1'b1;
      tick();
    end
    for (int k = 0; k < 16; k++) begin
      core_valid = 1'b1; core_rdata = cbytes[k];
      tick();
    end
    core_valid = (inject == 1); core_rdata = 8'hA5;
    tick();
    if (inject == 1) begin
      core_valid = 1'b0;
      checkOutput("gap_err_set", 512'(err), 512'd1);
      hold_bad = 1'b0;
      repeat (20) begin
        tick();
        if (err !== 1'b1 || msg_ready !== 1'b0 || res_valid !== 1'b0) hold_bad = 1'b1;
      end
      checkOutput("err_sticky", 512'(hold_bad), 512'd0);
      core_ien = 1'b0;
      return;
    end
    for (int k = 0; k < 32; k++) begin
      core_valid = 1'b1; core_rdata = tbytes[k];
      if (inject == 2 && k == 10) begin
        rst_n = 1'b0;
        tick();
        core_valid = 1'b0; core_ien = 1'b0;
        checkOutput("midrst_outputs", 512'(all_outs), 512'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_cfg_ready", 512'({msg_ready, cfg_ready}), 512'(2'b01));
        return;
      end
      if (k == 31) checkOutput("res_valid_early", 512'(res_valid), 512'd0);
      tick();
    end
    core_valid = 1'b0; core_rdata = 8'd0;
    checkOutput("res_valid_rise", 512'(res_valid), 512'd1);
    checkOutput("res_cipher", 512'(res_cipher), 512'(exp_cipher));
    checkOutput("res_tag", 512'(res_tag), 512'(exp_tag));
    checkOutput("core_mode_hold", 512'({mode_bad, core_mode}), 512'({1'b0, mode}));
    if (tail_left == 0) core_ien = 1'b0;
    hold_bad = 1'b0;
    repeat (hold) begin
      tick();
      if (tail_left > 0) begin
        tail_left--;
        if (tail_left == 0) core_ien = 1'b0;
      end
      if (res_valid !== 1'b1 || res_cipher !== exp_cipher || res_tag !== exp_tag ||
          msg_ready !== 1'b0) hold_bad = 1'b1;
    end
    if (hold > 0) checkOutput("hold_stable", 512'(hold_bad), 512'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("res_valid_drop", 512'(res_valid), 512'd0);
    if (core_ien) begin
      checkOutput("ready_waits_core", 512'(msg_ready), 512'd0);
      core_ien = 1'b0;
      tick();
    end
    checkOutput("msg_ready_back", 512'(msg_ready), 512'd1);
  endtask

  task automatic random_bytes();
    for (int k = 0; k < 16; k++) cbytes[k] = 8'($urandom());
    for (int k = 0; k < 32; k++) tbytes[k] = 8'($urandom());
  endtask

  initial begin
    logic [255:0] key;
    do_reset();

    // Counting key 00..1F, first byte in the top of the word.
    key = '0;
    for (int i = 0; i < 32; i++) key = {key[247:0], 8'(i)};
    send_key(key);
    finish_key(30);

    // A salt/key offer while keyed must not start a transfer.
    cfg_valid = 1'b1; cfg_data = {8{$urandom()}};
    tick();
    cfg_valid = 1'b0;
    checkOutput("cfg_ignored", 512'({core_start, msg_ready, cfg_ready}), 512'(3'b010));

    // Directed block with incrementing cipher and tag bytes.
    for (int k = 0; k < 16; k++) cbytes[k] = 8'(8'h10 + k);
    for (int k = 0; k < 32; k++) tbytes[k] = 8'(8'h20 + k);
    applyStimulus(128'h00112233445566778899AABBCCDDEEFF, 1'b1, 12, 2, 0, 0);

    // Long result backpressure.
    random_bytes();
    applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 20, 3, 50, 0);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 5; i++) begin
      random_bytes();
      applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()},
                    1'($urandom_range(0, 1)), int'($urandom_range(3, 40)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 0);
    end

    // Data in the cipher/tag gap is a protocol error.
    random_bytes();
    applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 8, 0, 0, 1);

    do_reset();
    send_key({8{$urandom()}});
    finish_key(int'($urandom_range(5, 40)));
    random_bytes();
    applyStimulus({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 10, 0, 0, 2);

    // Core that never finishes key derivation.
    send_key({8{$urandom()}});
    tick();
    core_ien = 1'b1;
    repeat (10000) tick();
`ifdef AES_LINK_TIMEOUT_EN
    checkOutput("watchdog_err", 512'(err), 512'd1);
`else
    checkOutput("no_watchdog_err", 512'(err), 512'd0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
